// File: rtl/c13_div_pkg.sv
// Shared definitions for the sequential restoring divider tile.
// Holds the FSM state type, the operand widths, the divide-by-zero result
// codes and the bit positions of the control/status pins on uio_*.
`timescale 1ns/1ps
package c13_div_pkg;

    localparam int N_BITS = 8;              // dividend / quotient width
    localparam int D_BITS = 4;              // divisor / remainder width
    localparam int CNT_W  = $clog2(N_BITS); // iteration counter width

    localparam logic [N_BITS-1:0] DBZ_QUOT = 8'hFF;
    localparam logic [D_BITS-1:0] DBZ_REM  = 4'hF;

    // Pin positions on the bidirectional bus
    localparam int START_BIT = 4;
    localparam int RSEL_BIT  = 5;
    localparam int BUSY_BIT  = 6;
    localparam int DONE_BIT  = 7;

    // busy and done are the only driven bidirectional pins
    localparam logic [7:0] UIO_OE_VAL = 8'b1100_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/c13_div_step.sv
// One combinational restoring-division step.
// Ports:
//   acc      in  partial remainder from the previous step
//   dq_msb   in  next dividend bit shifted into the partial remainder
//   dv       in  divisor
//   acc_next out partial remainder after the trial subtraction
//   q_bit    out quotient bit produced by this step
`timescale 1ns/1ps
module c13_div_step
    import c13_div_pkg::*;
(
    input  logic [D_BITS:0]   acc,
    input  logic              dq_msb,
    input  logic [D_BITS-1:0] dv,
    output logic [D_BITS:0]   acc_next,
    output logic              q_bit
);

    // Shifted partial remainder. acc stays below dv, so its top bit is
    // always 0; keeping it in the compare makes the step exact regardless.
    logic [D_BITS+1:0] t;

    always_comb begin
        t        = {acc, dq_msb};
        acc_next = t[D_BITS:0];
        q_bit    = 1'b0;
        if (t >= {2'b00, dv}) begin
            acc_next = t[D_BITS:0] - {1'b0, dv};
            q_bit    = 1'b1;
        end
    end

endmodule

// File: rtl/tt_um_c13_seq_divider.sv
// Tiny Tapeout tile: 8-bit by 4-bit sequential restoring divider.
// A start pulse latches the operands; the quotient and remainder appear
// after 8 iterations. Division by zero completes immediately with
// quotient FF, remainder F and the dbz flag set.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   ena         tile enable; when low every register holds
//   ui_in       dividend
//   uio_in      [3:0] divisor, [4] start, [5] rsel, [7:6] ignored
//   uo_out      rsel=0: quotient, rsel=1: {dbz, 3'b000, remainder}
//   uio_out     [6] busy, [7] done, others 0
//   uio_oe      constant 8'b1100_0000
`timescale 1ns/1ps
module tt_um_c13_seq_divider
    import c13_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t state, state_next;

    logic [N_BITS-1:0] dq;     // dividend shifting out, quotient shifting in
    logic [D_BITS-1:0] dv;
    logic [D_BITS:0]   acc;
    logic [CNT_W-1:0]  count;
    logic [N_BITS-1:0] quot;
    logic [D_BITS-1:0] rem;
    logic              dbz;

    logic              start;
    logic              rsel;
    logic [D_BITS-1:0] div_in;
    logic              busy;
    logic              done;
    logic              last_iter;
    logic [D_BITS:0]   acc_next;
    logic              q_bit;
    logic              unused;

    assign start     = uio_in[START_BIT];
    assign rsel      = uio_in[RSEL_BIT];
    assign div_in    = uio_in[D_BITS-1:0];
    assign unused    = &{uio_in[7:6], 1'b0};
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign last_iter = (count == CNT_W'(N_BITS - 1));

    c13_div_step u_step (
        .acc      (acc),
        .dq_msb   (dq[N_BITS-1]),
        .dv       (dv),
        .acc_next (acc_next),
        .q_bit    (q_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        state_next = state;
        if (ena) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = (div_in == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (last_iter) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dq    <= '0;
            dv    <= '0;
            acc   <= '0;
            count <= '0;
            quot  <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dq    <= ui_in;
                        dv    <= div_in;
                        acc   <= '0;
                        count <= '0;
                        if (div_in == '0) begin
                            quot <= DBZ_QUOT;
                            rem  <= DBZ_REM;
                            dbz  <= 1'b1;
                        end else begin
                            quot <= '0;
                            rem  <= '0;
                            dbz  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    dq    <= {dq[N_BITS-2:0], q_bit};
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        quot <= {dq[N_BITS-2:0], q_bit};
                        rem  <= acc_next[D_BITS-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Result view select is purely combinational over registered values
    always_comb begin
        uo_out = quot;
        if (rsel) begin
            uo_out = {dbz, 3'b000, rem};
        end
    end

    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = busy;
        uio_out[DONE_BIT] = done;
    end

    assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_c13_seq_divider.sv
`timescale 1ns/1ps
module tb_tt_um_c13_seq_divider;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [3:0] divisor;
  logic       start;
  logic       rsel;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Handshake: a start is accepted at a clock edge when rst_n=1, ena=1,
  // start=1 and busy=0; its result is valid on the first cycle where done=1.
  assign uio_in = {2'b10, rsel, start, divisor};

  always #5 clk = ~clk;

  tt_um_c13_seq_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  wire busy = uio_out[6];
  wire done = uio_out[7];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];  // {dbz, remainder, quotient}

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: arms on an accepted start, compares both result views when done
  initial begin : monitor
    logic        armed;
    logic [12:0] e;
    rsel  = 1'b0;
    armed = 1'b0;
    forever begin
      @(posedge clk);
      if (rst_n !== 1'b1) armed = 1'b0;
      else if (ena && start && !busy) armed = 1'b1;
      @(negedge clk);
      if (armed && done) begin
        armed = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("quotient_view", uo_out, e[7:0]);
          rsel = 1'b1;
          #1;
          check("remainder_view", uo_out, {e[12], 3'b000, e[11:8]});
          rsel = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_div(input logic [7:0] a, input logic [3:0] d,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez,
                         input int elat, input int ebusy,
                         input int stall_at, input int mid_at, input string tag);
    int n = 0;
    int nb = 0;
    int both = 0;
    exp_q.push_back({ez, er, eq});
    ui_in   = a;
    divisor = d;
    start   = 1'b1;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (busy) nb++;
      if (busy && done) both++;
      if (mid_at > 0 && n == mid_at) begin
        start = 1'b1; ui_in = 8'd50; divisor = 4'd5;
      end
      if (mid_at > 0 && n == mid_at + 1) start = 1'b0;
      if (stall_at > 0 && n == stall_at) ena = 1'b0;
      if (stall_at > 0 && n == stall_at + 3) ena = 1'b1;
      if (done || n >= 40) break;
    end
    check({tag, "_latency"}, n, elat);
    check({tag, "_busy_cycles"}, nb, ebusy);
    check({tag, "_busy_done_excl"}, both, 0);
  endtask

  task automatic reset_mid_run();
    int n = 0;
    ui_in = 8'd200; divisor = 4'd7; start = 1'b1;
    while (n < 5) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_uo_out", uo_out, 0);
    check("rst_mid_uio_out", uio_out, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int off;
    int idx;
    logic [7:0] a;
    logic [3:0] d;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; ui_in = 8'd0; divisor = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_uo_out", uo_out, 0);
    check("reset_uio_out", uio_out, 0);
    check("uio_oe", uio_oe, 8'hC0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(8'd200, 4'd7,  8'h1C, 4'd4, 1'b0, 9, 8, 0, 0, "d200_7");
    run_div(8'd255, 4'd1,  8'hFF, 4'd0, 1'b0, 9, 8, 0, 0, "d255_1");
    run_div(8'd225, 4'd15, 8'h0F, 4'd0, 1'b0, 9, 8, 0, 0, "d225_15");
    run_div(8'd3,   4'd9,  8'h00, 4'd3, 1'b0, 9, 8, 0, 0, "d3_9");
    run_div(8'd5,   4'd0,  8'hFF, 4'hF, 1'b1, 1, 0, 0, 0, "dbz_5_0");
    run_div(8'd100, 4'd3,  8'd33, 4'd1, 1'b0, 9, 8, 0, 4, "ignore_start");
    reset_mid_run();
    run_div(8'd200, 4'd7,  8'h1C, 4'd4, 1'b0, 12, 11, 4, 0, "ena_stall");

    // Sweep of every operand pair in a scrambled order (2731 is odd, so the
    // mapping is a permutation of 0..4095)
    off = $urandom_range(0, 4095);
    for (int i = 0; i < 4096; i++) begin
      idx = (i * 2731 + off) & 4095;
      a = idx[7:0];
      d = idx[11:8];
      if (d == 4'd0)
        run_div(a, d, 8'hFF, 4'hF, 1'b1, 1, 0, 0, 0, "sweep_dbz");
      else
        run_div(a, d, 8'(a / d), 4'(a % d), 1'b0, 9, 8, 0, 0, "sweep");
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
